// File: rtl/data_mem_responder.sv
// Single-port data memory responder: one valid/ready load/store at a time with
// RV32I byte/half/word lanes, configurable wait states and alignment/range faults.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [2:0]    f3_q, f3_d;
    logic          ready_q, ready_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;

    // Two-state storage starts at zero and is deliberately left out of reset.
    bit   [31:0]   mem_q [DEPTH_WORDS];

    logic          accept_c, access_c, err_c, mem_we_c;
    logic          cur_we;
    logic [31:0]   cur_addr, cur_wdata;
    logic [2:0]    cur_f3;
    logic [AW-1:0] idx_c;
    logic [31:0]   word_c, lane_c, load_c, wrep_c, merged_c;
    logic [3:0]    be_c;

    assign accept_c = req_valid && ready_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_c) state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
            ST_WAIT: if (cnt_q == '0) state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // With zero wait states the access happens on the accept edge, so it must see the live request.
    always_comb begin
        cur_we    = (state_q == ST_IDLE) ? req_we     : we_q;
        cur_addr  = (state_q == ST_IDLE) ? req_addr   : addr_q;
        cur_wdata = (state_q == ST_IDLE) ? req_wdata  : wdata_q;
        cur_f3    = (state_q == ST_IDLE) ? req_funct3 : f3_q;
        idx_c     = cur_addr[AW+1:2];
        word_c    = 32'(mem_q[idx_c]);
        lane_c    = word_c >> {cur_addr[1:0], 3'b000};

        err_c = 1'b0;
        case (cur_f3)
            3'b000:  err_c = 1'b0;
            3'b100:  err_c = cur_we;
            3'b001:  err_c = cur_addr[0];
            3'b101:  err_c = cur_we | cur_addr[0];
            3'b010:  err_c = |cur_addr[1:0];
            default: err_c = 1'b1;
        endcase
        if ((cur_addr >> 2) >= 32'(DEPTH_WORDS)) err_c = 1'b1;

        load_c = '0;
        be_c   = '0;
        wrep_c = cur_wdata;
        case (cur_f3)
            3'b000: load_c = {{24{lane_c[7]}}, lane_c[7:0]};
            3'b100: load_c = {24'd0, lane_c[7:0]};
            3'b001: load_c = {{16{lane_c[15]}}, lane_c[15:0]};
            3'b101: load_c = {16'd0, lane_c[15:0]};
            3'b010: load_c = word_c;
            default: load_c = '0;
        endcase
        case (cur_f3[1:0])
            2'b00: begin
                be_c   = 4'b0001 << cur_addr[1:0];
                wrep_c = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                be_c   = 4'b0011 << {cur_addr[1], 1'b0};
                wrep_c = {2{cur_wdata[15:0]}};
            end
            2'b10:   be_c = 4'b1111;
            default: be_c = 4'b0000;
        endcase
        merged_c = word_c;
        for (int b = 0; b < 4; b++) begin
            if (be_c[b]) merged_c[8*b +: 8] = wrep_c[8*b +: 8];
        end

        access_c = ((state_q == ST_IDLE) && accept_c && (WAIT_CYCLES == 0)) ||
                   ((state_q == ST_WAIT) && (cnt_q == '0));
        mem_we_c = access_c && cur_we && !err_c;
    end

    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_RESP);

        if ((state_q == ST_IDLE) && accept_c) begin
            we_d    = req_we;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            f3_d    = req_funct3;
            cnt_d   = WAIT_LOAD;
        end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
            cnt_d = cnt_q - 4'd1;
        end

        if (access_c) begin
            err_d   = err_c;
            rdata_d = (err_c || cur_we) ? 32'd0 : load_c;
        end else if ((state_q == ST_RESP) && rsp_ready) begin
            err_d   = 1'b0;
            rdata_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we_c) mem_q[idx_c] <= merged_c;
    end

    assign req_ready = ready_q;
    assign rsp_valid = valid_q;
    assign rsp_err   = err_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed checks plus randomized loads/stores
// scored against a byte-array reference model; second instance with 3 wait states.
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned TMO   = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
    logic [2:0]  a_req_funct3;
    logic        b_reset, b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
    logic [2:0]  b_req_funct3;

    int n_cmp = 0;
    int n_mis = 0;
    logic [7:0] ref_mem [DEPTH*4];

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) u_dut_a (
        .clk(clk), .reset(a_reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_funct3(a_req_funct3),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u_dut_b (
        .clk(clk), .reset(b_reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_funct3(b_req_funct3),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: byte-addressed memory, faults decided from the width/alignment/range rules.
    function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [2:0] f3, output logic [31:0] rdata, output logic err);
        int size;
        logic [31:0] v;
        err = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]) ||
              ((f3[1:0] == 2'b01) && addr[0]) || ((f3 == 3'b010) && (addr[1:0] != 2'b00)) ||
              ((addr >> 2) >= DEPTH);
        rdata = 32'd0;
        if (err) return;
        size = 1 << f3[1:0];
        if (we) begin
            for (int i = 0; i < size; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < size; i++) v = v | (32'(ref_mem[int'(addr) + i]) << (8*i));
            if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
            if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
            rdata = v;
        end
    endfunction

    task automatic a_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, input int hold,
                         output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        check("a_ready_before_req", 32'(a_req_ready), 32'd1);
        check("a_valid_before_req", 32'(a_rsp_valid), 32'd0);
        a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata; a_req_funct3 = f3;
        @(posedge clk);
        #1;
        a_req_valid = 1'b0; a_req_we = 1'($urandom); a_req_addr = $urandom;
        a_req_wdata = $urandom; a_req_funct3 = 3'($urandom);
        lat = 1;
        rd = 'x; er = 1'bx;
        forever begin
            @(negedge clk);
            if (a_rsp_valid) break;
            if (lat > int'(TMO)) begin
                n_cmp++; n_mis++;
                $error("FAIL a_rsp_timeout: observed no rsp_valid after %0d cycles expected 2", lat);
                return;
            end
            @(posedge clk);
            lat++;
        end
        rd = a_rsp_rdata;
        er = a_rsp_err;
        for (int h = 0; h < hold; h++) begin
            check("a_hold_valid", 32'(a_rsp_valid), 32'd1);
            check("a_hold_rdata", a_rsp_rdata, rd);
            check("a_hold_err", 32'(a_rsp_err), 32'(er));
            check("a_hold_ready", 32'(a_req_ready), 32'd0);
            a_req_valid = 1'($urandom); a_req_we = 1'($urandom); a_req_addr = $urandom;
            a_req_wdata = $urandom; a_req_funct3 = 3'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        // A request offered in the handshake cycle must not be taken.
        check("a_ready_in_handshake", 32'(a_req_ready), 32'd0);
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = $urandom_range(0, 255);
        a_req_wdata = $urandom; a_req_funct3 = 3'b010;
        a_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        a_rsp_ready = 1'b0;
        a_req_valid = 1'b0;
    endtask

    task automatic a_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input int hold,
                        output logic [31:0] rd, output logic er);
        logic [31:0] exp_rd;
        logic exp_er;
        int lat;
        model(we, addr, wdata, f3, exp_rd, exp_er);
        a_req(we, addr, wdata, f3, hold, rd, er, lat);
        check($sformatf("a_rdata@%08h f3=%0d we=%0d", addr, f3, we), rd, exp_rd);
        check($sformatf("a_err@%08h f3=%0d we=%0d", addr, f3, we), 32'(er), 32'(exp_er));
        check("a_latency", 32'(lat), 32'd2);
    endtask

    task automatic b_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        check("b_ready_before_req", 32'(b_req_ready), 32'd1);
        b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata; b_req_funct3 = f3;
        @(posedge clk);
        #1;
        b_req_valid = 1'b0; b_req_addr = $urandom; b_req_wdata = $urandom;
        lat = 1;
        rd = 'x; er = 1'bx;
        forever begin
            @(negedge clk);
            if (b_rsp_valid) break;
            if (lat > int'(TMO)) begin
                n_cmp++; n_mis++;
                $error("FAIL b_rsp_timeout: observed no rsp_valid after %0d cycles expected 4", lat);
                return;
            end
            @(posedge clk);
            lat++;
        end
        rd = b_rsp_rdata;
        er = b_rsp_err;
        b_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        b_rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic er;
        int lat;
        int waited;

        for (int i = 0; i < int'(DEPTH) * 4; i++) ref_mem[i] = 8'h00;
        a_reset = 1'b1; a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0;
        a_req_wdata = '0; a_req_funct3 = '0; a_rsp_ready = 1'b0;
        b_reset = 1'b1; b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0;
        b_req_wdata = '0; b_req_funct3 = '0; b_rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("a_reset_valid", 32'(a_rsp_valid), 32'd0);
        check("a_reset_err", 32'(a_rsp_err), 32'd0);
        check("a_reset_rdata", a_rsp_rdata, 32'd0);
        a_reset = 1'b0;
        b_reset = 1'b0;
        @(negedge clk);
        check("a_ready_after_reset", 32'(a_req_ready), 32'd1);
        check("b_ready_after_reset", 32'(b_req_ready), 32'd1);

        // Word store then load back.
        a_op(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, rd, er);
        check("sw_0x10_err", 32'(er), 32'd0);
        a_op(1'b0, 32'h10, 32'h0, 3'b010, 0, rd, er);
        check("lw_0x10", rd, 32'hDEADBEEF);

        // Byte lane with sign/zero extension.
        a_op(1'b1, 32'h21, 32'h80, 3'b000, 0, rd, er);
        a_op(1'b0, 32'h21, 32'h0, 3'b000, 0, rd, er);
        check("lb_0x21", rd, 32'hFFFFFF80);
        a_op(1'b0, 32'h21, 32'h0, 3'b100, 0, rd, er);
        check("lbu_0x21", rd, 32'h00000080);
        a_op(1'b0, 32'h20, 32'h0, 3'b010, 0, rd, er);
        check("lw_0x20", rd, 32'h00008000);

        // Half lane and misaligned half.
        a_op(1'b1, 32'h32, 32'h8001, 3'b001, 0, rd, er);
        a_op(1'b0, 32'h32, 32'h0, 3'b001, 0, rd, er);
        check("lh_0x32", rd, 32'hFFFF8001);
        a_op(1'b0, 32'h32, 32'h0, 3'b101, 0, rd, er);
        check("lhu_0x32", rd, 32'h00008001);
        a_op(1'b0, 32'h33, 32'h0, 3'b001, 0, rd, er);
        check("lh_0x33_err", 32'(er), 32'd1);
        check("lh_0x33_rdata", rd, 32'd0);

        // Out-of-range and misaligned stores write nothing.
        a_op(1'b1, 32'h400, 32'h11223344, 3'b010, 0, rd, er);
        check("sw_0x400_err", 32'(er), 32'd1);
        a_op(1'b0, 32'h0, 32'h0, 3'b010, 0, rd, er);
        check("lw_0x000", rd, 32'd0);
        a_op(1'b1, 32'h6, 32'h55667788, 3'b010, 0, rd, er);
        check("sw_0x6_err", 32'(er), 32'd1);
        a_op(1'b0, 32'h4, 32'h0, 3'b010, 0, rd, er);
        check("lw_0x4_untouched", rd, 32'd0);

        // Response back-pressure for five cycles.
        a_op(1'b0, 32'h10, 32'h0, 3'b010, 5, rd, er);
        check("lw_0x10_held", rd, 32'hDEADBEEF);

        // Reset while the store response is pending: response dropped, write kept.
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h50;
        a_req_wdata = 32'hCAFEF00D; a_req_funct3 = 3'b010;
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        waited = 0;
        while (!a_rsp_valid && waited < int'(TMO)) begin
            @(negedge clk);
            waited++;
        end
        check("a_resp_before_reset", 32'(a_rsp_valid), 32'd1);
        model(1'b1, 32'h50, 32'hCAFEF00D, 3'b010, rd, er);
        a_reset = 1'b1;
        #1;
        check("a_resp_dropped_valid", 32'(a_rsp_valid), 32'd0);
        check("a_resp_dropped_err", 32'(a_rsp_err), 32'd0);
        @(negedge clk);
        a_reset = 1'b0;
        a_op(1'b0, 32'h50, 32'h0, 3'b010, 0, rd, er);
        check("lw_0x50_after_reset", rd, 32'hCAFEF00D);

        // Randomized traffic, mostly in a small window so stores and loads collide.
        for (int n = 0; n < 200; n++) begin
            logic [31:0] addr;
            addr = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(0, 32'h7FF)) : 32'($urandom_range(0, 127));
            a_op(1'($urandom), addr, $urandom, 3'($urandom), int'($urandom_range(0, 2)), rd, er);
        end

        // Three wait states: reset one cycle after accepting a store aborts it.
        @(negedge clk);
        b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 32'h40;
        b_req_wdata = 32'h12345678; b_req_funct3 = 3'b010;
        @(posedge clk);
        #1;
        b_req_valid = 1'b0;
        @(posedge clk);
        #1;
        b_reset = 1'b1;
        #1;
        check("b_abort_valid", 32'(b_rsp_valid), 32'd0);
        check("b_abort_err", 32'(b_rsp_err), 32'd0);
        check("b_abort_rdata", b_rsp_rdata, 32'd0);
        @(negedge clk);
        b_reset = 1'b0;
        b_req(1'b0, 32'h40, 32'h0, 3'b010, rd, er, lat);
        check("b_lw_0x40_aborted", rd, 32'd0);
        check("b_lw_0x40_err", 32'(er), 32'd0);
        check("b_latency_load", 32'(lat), 32'd4);
        b_req(1'b1, 32'h44, 32'hA5A5C3C3, 3'b010, rd, er, lat);
        check("b_latency_store", 32'(lat), 32'd4);
        b_req(1'b0, 32'h46, 32'h0, 3'b101, rd, er, lat);
        check("b_lhu_0x46", rd, 32'h0000A5A5);
        b_req(1'b0, 32'h47, 32'h0, 3'b001, rd, er, lat);
        check("b_lh_0x47_err", 32'(er), 32'd1);
        check("b_latency_err", 32'(lat), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
